// File: rtl/alu_share_if.sv
// Bundle between the two ALU requesters, the shared ALU and the response consumer.
// The arbiter takes the slave view; the surrounding logic takes the master view.
interface alu_share_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 2
);
  logic              Req0;
  logic [DATA_W-1:0] ReqOp1_0;
  logic [DATA_W-1:0] ReqOp2_0;
  logic [OP_W-1:0]   ReqAluOp0;
  logic              ReqReady0;

  logic              Req1;
  logic [DATA_W-1:0] ReqOp1_1;
  logic [DATA_W-1:0] ReqOp2_1;
  logic [OP_W-1:0]   ReqAluOp1;
  logic              ReqReady1;

  logic [DATA_W-1:0] AluOperand1;
  logic [DATA_W-1:0] AluOperand2;
  logic [OP_W-1:0]   AluOperation;
  logic [DATA_W-1:0] AluResult;
  logic              AluZero;

  logic              RespValid;
  logic              RespReady;
  logic              RespId;
  logic [DATA_W-1:0] RespResult;
  logic              RespZero;

  modport slave (
    input  Req0, ReqOp1_0, ReqOp2_0, ReqAluOp0,
    input  Req1, ReqOp1_1, ReqOp2_1, ReqAluOp1,
    output ReqReady0, ReqReady1,
    output AluOperand1, AluOperand2, AluOperation,
    input  AluResult, AluZero,
    output RespValid, RespId, RespResult, RespZero,
    input  RespReady
  );

  modport master (
    output Req0, ReqOp1_0, ReqOp2_0, ReqAluOp0,
    output Req1, ReqOp1_1, ReqOp2_1, ReqAluOp1,
    input  ReqReady0, ReqReady1,
    input  AluOperand1, AluOperand2, AluOperation,
    output AluResult, AluZero,
    input  RespValid, RespId, RespResult, RespZero,
    output RespReady
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; one operation in flight,
// registered ALU inputs, captured result returned over a valid/ready response port.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 2
) (
  input logic       clk,
  input logic       reset,
  alu_share_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              resp_id_q, resp_id_d;
  logic [DATA_W-1:0] resp_result_q, resp_result_d;
  logic              resp_zero_q, resp_zero_d;
  logic [DATA_W-1:0] alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0] alu_op2_q, alu_op2_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;

  logic grant0, grant1, ready0, ready1, accept;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant0 = bus.Req0 & (~bus.Req1 | last_grant_q);
    grant1 = bus.Req1 & (~bus.Req0 | ~last_grant_q);
    ready0 = ~reset & (state_q == StIdle) & grant0;
    ready1 = ~reset & (state_q == StIdle) & grant1;
    accept = ready0 | ready1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      alu_op_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      alu_op1_q     <= alu_op1_d;
      alu_op2_q     <= alu_op2_d;
      alu_op_q      <= alu_op_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    alu_op1_d     = alu_op1_q;
    alu_op2_d     = alu_op2_q;
    alu_op_d      = alu_op_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StExec;
          last_grant_d = ready1;
          resp_id_d    = ready1;
          if (ready1) begin
            alu_op1_d = bus.ReqOp1_1;
            alu_op2_d = bus.ReqOp2_1;
            alu_op_d  = bus.ReqAluOp1;
          end else begin
            alu_op1_d = bus.ReqOp1_0;
            alu_op2_d = bus.ReqOp2_0;
            alu_op_d  = bus.ReqAluOp0;
          end
        end
      end
      StExec: begin
        resp_result_d = bus.AluResult;
        resp_zero_d   = bus.AluZero;
        state_d       = StResp;
      end
      StResp: begin
        if (bus.RespReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.ReqReady0    = ready0;
    bus.ReqReady1    = ready1;
    bus.AluOperand1  = alu_op1_q;
    bus.AluOperand2  = alu_op2_q;
    bus.AluOperation = alu_op_q;
    bus.RespValid    = (state_q == StResp);
    bus.RespId       = resp_id_q;
    bus.RespResult   = resp_result_q;
    bus.RespZero     = resp_zero_q;
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared port.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  alu_share_if #(.DATA_W(32), .OP_W(2)) bus ();

  alu_share_arbiter #(.DATA_W(32), .OP_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (bus.AluOperation)
      2'b00:   bus.AluResult = bus.AluOperand1 + bus.AluOperand2;
      2'b01:   bus.AluResult = bus.AluOperand1 - bus.AluOperand2;
      2'b10:   bus.AluResult = bus.AluOperand2 << 16;
      default: bus.AluResult = bus.AluOperand1 | bus.AluOperand2;
    endcase
    bus.AluZero = (bus.AluResult == 32'd0);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge where a ReqReady is first seen, or after budget cycles.
  task automatic wait_ready(input int budget, output int waited, output bit ok);
    waited = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.ReqReady0 || bus.ReqReady1) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
  endtask

  task automatic set_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
    if (id == 1'b0) begin
      bus.ReqOp1_0 = a; bus.ReqOp2_0 = b; bus.ReqAluOp0 = op; bus.Req0 = 1'b1;
    end else begin
      bus.ReqOp1_1 = a; bus.ReqOp2_1 = b; bus.ReqAluOp1 = op; bus.Req1 = 1'b1;
    end
  endtask

  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] exp_res, input bit exp_zero);
    int w;
    bit ok;
    @(posedge clk); #1;
    set_req(id, a, b, op);
    wait_ready(20, w, ok);
    check_val("accept_seen", {31'd0, ok}, 32'd1);
    check_val("accept_id", {31'd0, bus.ReqReady1}, {31'd0, id});
    @(posedge clk); #1;
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    @(negedge clk);
    check_val("exec_no_valid", {31'd0, bus.RespValid}, 32'd0);
    @(negedge clk);
    check_val("resp_valid", {31'd0, bus.RespValid}, 32'd1);
    check_val("resp_id", {31'd0, bus.RespId}, {31'd0, id});
    check_val("resp_result", bus.RespResult, exp_res);
    check_val("resp_zero", {31'd0, bus.RespZero}, {31'd0, exp_zero});
  endtask

  initial begin
    int  w;
    bit  ok;
    reset = 1'b1;
    bus.RespReady = 1'b1;
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    set_req(1'b0, 32'd1, 32'd1, 2'b00);
    set_req(1'b1, 32'd10, 32'd4, 2'b01);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready0", {31'd0, bus.ReqReady0}, 32'd0);
    check_val("rst_ready1", {31'd0, bus.ReqReady1}, 32'd0);
    check_val("rst_valid", {31'd0, bus.RespValid}, 32'd0);
    check_val("rst_id", {31'd0, bus.RespId}, 32'd0);
    check_val("rst_result", bus.RespResult, 32'd0);
    check_val("rst_operand1", bus.AluOperand1, 32'd0);
    check_val("rst_operation", {30'd0, bus.AluOperation}, 32'd0);

    // Both requesters held right after reset: grants alternate 0,1,0,1 back to back.
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ready(20, w, ok);
      check_val("rr_seen", {31'd0, ok}, 32'd1);
      check_val("rr_wait", w, 32'd0);
      check_val("rr_ready0", {31'd0, bus.ReqReady0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check_val("rr_ready1", {31'd0, bus.ReqReady1}, (k % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      if (k == 3) begin
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      check_val("rr_valid", {31'd0, bus.RespValid}, 32'd1);
      check_val("rr_id", {31'd0, bus.RespId}, (k % 2 == 1) ? 32'd1 : 32'd0);
      check_val("rr_result", bus.RespResult, (k % 2 == 1) ? 32'd6 : 32'd2);
    end

    run_op(1'b0, 32'd5, 32'd3, 2'b00, 32'd8, 1'b0);
    run_op(1'b0, 32'hDEAD, 32'h1234, 2'b10, 32'h12340000, 1'b0);
    run_op(1'b1, 32'd7, 32'd7, 2'b01, 32'd0, 1'b1);
    run_op(1'b1, 32'hF0, 32'h0F, 2'b11, 32'hFF, 1'b0);

    // Backpressure: response held while requester 1 waits.
    @(posedge clk); #1;
    bus.RespReady = 1'b0;
    set_req(1'b0, 32'd2, 32'd2, 2'b00);
    set_req(1'b1, 32'd10, 32'd4, 2'b01);
    wait_ready(20, w, ok);
    check_val("bp_ready0", {31'd0, bus.ReqReady0}, 32'd1);
    @(posedge clk); #1;
    bus.Req0 = 1'b0;
    @(negedge clk);
    check_val("bp_exec_ready1", {31'd0, bus.ReqReady1}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp_valid", {31'd0, bus.RespValid}, 32'd1);
      check_val("bp_id", {31'd0, bus.RespId}, 32'd0);
      check_val("bp_result", bus.RespResult, 32'd4);
      check_val("bp_ready1", {31'd0, bus.ReqReady1}, 32'd0);
    end
    bus.RespReady = 1'b1;
    @(negedge clk);
    check_val("bp_after_valid", {31'd0, bus.RespValid}, 32'd0);
    check_val("bp_after_ready1", {31'd0, bus.ReqReady1}, 32'd1);
    @(posedge clk); #1;
    bus.Req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("bp2_valid", {31'd0, bus.RespValid}, 32'd1);
    check_val("bp2_id", {31'd0, bus.RespId}, 32'd1);
    check_val("bp2_result", bus.RespResult, 32'd6);

    // Reset while the operation is in EXEC: it must vanish without a response.
    @(posedge clk); #1;
    set_req(1'b0, 32'd9, 32'd9, 2'b01);
    wait_ready(20, w, ok);
    check_val("mr_accept", {31'd0, bus.ReqReady0}, 32'd1);
    @(posedge clk); #1;
    bus.Req0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_val("mr_ready0", {31'd0, bus.ReqReady0}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("mr_valid", {31'd0, bus.RespValid}, 32'd0);
    check_val("mr_id", {31'd0, bus.RespId}, 32'd0);
    check_val("mr_result", bus.RespResult, 32'd0);
    check_val("mr_zero", {31'd0, bus.RespZero}, 32'd0);
    check_val("mr_operand1", bus.AluOperand1, 32'd0);
    check_val("mr_operand2", bus.AluOperand2, 32'd0);
    check_val("mr_operation", {30'd0, bus.AluOperation}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("mr_no_resp", {31'd0, bus.RespValid}, 32'd0);
    end

    run_op(1'b0, 32'hFFFFFFFF, 32'd1, 2'b00, 32'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
